shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle shift controller for the datapath's single-position shifter.
- Accepts a value, a shift op and a shift amount, then drives an external 1-bit Shifter instance once per cycle until the amount is consumed.
- Returns the result with a one-cycle done pulse.
- Sits between the datapath controller FSM and the shifter, giving the datapath variable-distance shifts without a barrel shifter.

Parameters:
WIDTH, 16, datapath word width; must match the attached Shifter instance.
AMT_W, 4, width of shift amount; max distance 2^AMT_W-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
in  input  WIDTH  operand, captured when start is accepted
op  input  2  shift op: 00 pass, 01 shift left (zero fill), 10 logical right (zero fill), 11 arithmetic right (MSB replicated)
amt  input  AMT_W  number of 1-bit shift steps
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid on out
out  output  WIDTH  last completed result; held until next accepted start
sh_in  output  WIDTH  operand to Shifter
sh_shift  output  2  op to Shifter
sh_out  input  WIDTH  Shifter result (combinational from sh_in/sh_shift)

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, count=0, out=0, done=0, busy=0, sh_shift=00.
- Reset asserted mid-operation aborts the operation. No done pulse is produced. out returns to 0.
- Registers:
  - acc (WIDTH): working value.
  - op_r (2): latched op.
  - count (AMT_W): steps remaining.
- sh_in = acc at all times.
- sh_shift = op_r in SHIFT, 00 otherwise.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - acc<=in, op_r<=op, count<=amt.
  - If amt==0: next state DONE.
  - Else: next state SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT, each edge:
  - acc<=sh_out, count<=count-1.
  - If count==1: next state DONE.
- DONE:
  - done=1 for exactly this cycle; out<=acc at the edge leaving DONE (out also driven =acc combinationally while in DONE).
  - Next state IDLE unconditionally.
- Latency:
  - amt==0: done high in the cycle after E0.
  - amt>=1: done high in the cycle after edge E_amt.
  - No new request is accepted before the cycle after done.
- start while busy (SHIFT or DONE): ignored, no side effects. Inputs are not re-sampled.
- op==00 with amt>0: performs amt pass-through steps; result equals in.
- Arithmetic right by amount >= WIDTH-1 saturates to all-sign bits. Logical shifts by >= WIDTH yield 0. Both follow naturally from iteration.
- in, op and amt may change freely after the start edge.

Optional Feature:
SHIFT_SEQ_EARLY_EXIT_EN
- Defined: in SHIFT, before performing a step, if acc is a fixed point of op_r, next state is DONE and count is discarded. Fixed points:
  - op_r 00: always.
  - 01/10: acc==0.
  - 11: acc all-0 or all-1.
- Defined: the result is identical to the full iteration; only latency shrinks.
- Not defined: always exactly amt steps, as specified above.

Test Plan:
1. Reset asserted, then start with op=01, in=16'h000F, amt=4 -> busy 1 for E0..E4, done pulse in cycle after E4, out=16'h00F0; out holds after done.
2. op=10, in=16'h8000, amt=15 -> out=16'h0001, done in cycle after E15; op=11, in=16'h8000, amt=3 -> out=16'hF000; op=11, in=16'h4000, amt=3 -> out=16'h0800.
3. op=01, in=16'h1234, amt=0 -> done in cycle after E0, out=16'h1234, no SHIFT cycles (sh_shift stays 00).
4. During test 1, pulse start with in=16'hFFFF at E2 -> ignored; out=16'h00F0; single done pulse.
5. Start op=01, in=16'h0001, amt=8; assert reset at E3 -> busy/done/out immediately 0, state IDLE. Next start (in=16'h0001, amt=1) -> out=16'h0002.
6. op=10, in=16'h0003, amt=10 -> out=16'h0000. Done timing depends on the macro:
   - Without SHIFT_SEQ_EARLY_EXIT_EN: done after E10.
   - With it: done after E3.

Source files
------------

// File: rtl/shift_sequencer.sv
// Variable-distance shifter built by stepping an external 1-bit shifter once per cycle.
// Latency: done in cycle after last step (amt steps; amt==0 -> next cycle). start ignored while busy.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: stop stepping once acc is a fixed point of the op.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] sh_in,
    output logic [1:0]       sh_shift,
    input  logic [WIDTH-1:0] sh_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= 2'b00;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    logic fixed_pt;

    // Further steps cannot change acc, so finishing now gives the same result.
    always_comb begin
        fixed_pt = 1'b0;
        case (op_q)
            2'b00:   fixed_pt = 1'b1;
            2'b01,
            2'b10:   fixed_pt = (acc_q == '0);
            default: fixed_pt = (acc_q == '0) || (acc_q == '1);
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        count_d = count_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = in;
                    op_d    = op;
                    count_d = amt;
                    state_d = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                if (fixed_pt) begin
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    acc_d   = sh_out;
                    count_d = count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1))
                        state_d = DONE;
                end
`else
                acc_d   = sh_out;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1))
                    state_d = DONE;
`endif
            end
            DONE: begin
                out_d   = acc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    // Result is visible during the done cycle, before out_q captures it.
    assign out      = (state_q == DONE) ? acc_q : out_q;
    assign sh_in    = acc_q;
    assign sh_shift = (state_q == SHIFT) ? op_q : 2'b00;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 1-bit shifter attached.
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in;
    logic [1:0]       op;
    logic [AMT_W-1:0] amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] sh_in;
    logic [1:0]       sh_shift;
    logic [WIDTH-1:0] sh_out;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in       (in),
        .op       (op),
        .amt      (amt),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .sh_in    (sh_in),
        .sh_shift (sh_shift),
        .sh_out   (sh_out)
    );

    // External single-position shifter
    always_comb begin
        sh_out = sh_in;
        case (sh_shift)
            2'b01:   sh_out = {sh_in[WIDTH-2:0], 1'b0};
            2'b10:   sh_out = {1'b0, sh_in[WIDTH-1:1]};
            2'b11:   sh_out = {sh_in[WIDTH-1], sh_in[WIDTH-1:1]};
            default: sh_out = sh_in;
        endcase
    end

    typedef struct {
        string            name;
        logic [1:0]       op;
        logic [WIDTH-1:0] in;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] exp_out;
        int               lat_full;
        int               lat_early;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op_i, input logic [WIDTH-1:0] in_i,
                          input logic [AMT_W-1:0] amt_i, input logic [WIDTH-1:0] exp_o,
                          input int exp_lat, input bit inject);
        int   first;
        int   nd;
        bit   saw_shift;
        bit   busy_bad;
        logic [WIDTH-1:0] got;
        first = -1; nd = 0; saw_shift = 0; busy_bad = 0; got = '0;
        @(negedge clk);
        start = 1'b1; op = op_i; in = in_i; amt = amt_i;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; in = 16'h5A5A; op = ~op_i; amt = ~amt_i;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                nd++;
                if (first < 0) begin
                    first = k;
                    got   = out;
                end
            end
            if (sh_shift != 2'b00) saw_shift = 1;
            if ((first < 0 || first == k) && !busy) busy_bad = 1;
            if (inject && k == 1) begin
                start = 1'b1; in = 16'hFFFF; op = 2'b01; amt = 4'd1;
            end else if (inject && k == 2) begin
                start = 1'b0;
            end
            if (first >= 0 && k == first + 2) break;
        end
        chk({nm, " latency"}, first, exp_lat);
        chk({nm, " out@done"}, got, exp_o);
        chk({nm, " done pulses"}, nd, 1);
        chk({nm, " out held"}, out, exp_o);
        chk({nm, " busy after"}, busy, 1'b0);
        chk({nm, " busy during"}, busy_bad, 1'b0);
        if (amt_i == '0) chk({nm, " no shift cycles"}, saw_shift, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"sll4",      2'b01, 16'h000F, 4'd4,  16'h00F0, 4,  4});
        vecs.push_back('{"srl15",     2'b10, 16'h8000, 4'd15, 16'h0001, 15, 15});
        vecs.push_back('{"sra3neg",   2'b11, 16'h8000, 4'd3,  16'hF000, 3,  3});
        vecs.push_back('{"sra3pos",   2'b11, 16'h4000, 4'd3,  16'h0800, 3,  3});
        vecs.push_back('{"amt0",      2'b01, 16'h1234, 4'd0,  16'h1234, 0,  0});
        vecs.push_back('{"srl10",     2'b10, 16'h0003, 4'd10, 16'h0000, 10, 3});
        vecs.push_back('{"pass5",     2'b00, 16'hABCD, 4'd5,  16'hABCD, 5,  1});
        vecs.push_back('{"sraones",   2'b11, 16'hFFFF, 4'd2,  16'hFFFF, 2,  1});
        vecs.push_back('{"sra15sat",  2'b11, 16'h8000, 4'd15, 16'hFFFF, 15, 15});
        vecs.push_back('{"sll15",     2'b01, 16'h0001, 4'd15, 16'h8000, 15, 15});
        vecs.push_back('{"srl15ones", 2'b10, 16'hFFFF, 4'd15, 16'h0001, 15, 15});

        reset = 1'b1; start = 1'b0; in = '0; op = 2'b00; amt = '0;
        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset out", out, 16'h0000);
        chk("reset sh_shift", sh_shift, 2'b00);
        chk("reset sh_in", sh_in, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
            run_op(vecs[i].name, vecs[i].op, vecs[i].in, vecs[i].amt, vecs[i].exp_out, vecs[i].lat_early, 1'b0);
`else
            run_op(vecs[i].name, vecs[i].op, vecs[i].in, vecs[i].amt, vecs[i].exp_out, vecs[i].lat_full, 1'b0);
`endif
        end

        // start pulsed at E2 of a running op must be ignored
        run_op("busy start", 2'b01, 16'h000F, 4'd4, 16'h00F0, 4, 1'b1);

        // reset mid-operation: out currently 00F0 and must clear
        @(negedge clk);
        start = 1'b1; op = 2'b01; in = 16'h0001; amt = 4'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset busy", busy, 1'b1);
        chk("pre-reset sh_in", sh_in, 16'h0008);
        reset = 1'b1;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort out", out, 16'h0000);
        chk("abort sh_shift", sh_shift, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        run_op("post-reset", 2'b01, 16'h0001, 4'd1, 16'h0002, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
